// File: rtl/program_sequencer.sv
// Multi-cycle fetch/execute/load-wait sequencer. It owns the program counter,
// qualifies the decoder's write controls into strobes, and runs the req/done handshake.
module program_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            halt,
  input  logic            Branch,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] prog_ctr,
  output logic            fetch_en,
  output logic            reg_we,
  output logic            mem_we,
  output logic            mem_re,
  output logic            busy,
  output logic            done,
  output logic [CT_W-1:0] cycle_ct
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CT_W-1:0] ct_q, ct_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ct_d     = ct_q;
    fetch_en = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    done     = 1'b0;
    busy     = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEMWAIT);

    // The cycle counter saturates so that long runs never alias to small counts.
    if (busy && (ct_q != '1)) ct_d = ct_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
          ct_d    = '0;
        end
      end
      FETCH: begin
        fetch_en = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        if (halt) begin
          state_d = DONE;
        end else if (MemtoReg) begin
          // A load wins over a store; the write-back happens in MEMWAIT.
          mem_re  = 1'b1;
          state_d = MEMWAIT;
        end else begin
          reg_we  = RegWrite;
          mem_we  = MemWrite;
          pc_d    = (Branch && cond) ? target : pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      MEMWAIT: begin
        reg_we  = 1'b1;
        pc_d    = pc_q + 1'b1;
        state_d = FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prog_ctr = pc_q;
  assign cycle_ct = ct_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer. A second instance with START_ADDR=0x3FF
// and CT_W=4 covers PC wrap and counter saturation.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, halt, Branch, MemtoReg, MemWrite, RegWrite, cond;
  logic [9:0] target;

  logic [9:0]  prog_ctr,  prog_ctr2;
  logic        fetch_en,  fetch_en2, reg_we, reg_we2, mem_we, mem_we2;
  logic        mem_re,    mem_re2,   busy,   busy2,   done,   done2;
  logic [15:0] cycle_ct;
  logic [3:0]  cycle_ct2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .Branch(Branch),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite), .cond(cond),
    .target(target), .prog_ctr(prog_ctr), .fetch_en(fetch_en), .reg_we(reg_we),
    .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done), .cycle_ct(cycle_ct)
  );

  program_sequencer #(.PC_W(10), .START_ADDR(10'h3FF), .CT_W(4)) dut2 (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .Branch(Branch),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite), .cond(cond),
    .target(target), .prog_ctr(prog_ctr2), .fetch_en(fetch_en2), .reg_we(reg_we2),
    .mem_we(mem_we2), .mem_re(mem_re2), .busy(busy2), .done(done2), .cycle_ct(cycle_ct2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_dec();
    halt = 0; Branch = 0; MemtoReg = 0; MemWrite = 0; RegWrite = 0; cond = 0; target = '0;
  endtask

  task automatic strobes(input string tag, input logic [3:0] exp);
    chk(tag, {fetch_en, reg_we, mem_we, mem_re}, exp);
  endtask

  initial begin
    reset = 0; req = 0; clr_dec();

    // Reset then idle
    repeat (3) tick();
    #1;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_ct", cycle_ct, 0);
    reset = 1;
    repeat (5) tick();
    #1;
    chk("idle_pc", prog_ctr, 0);
    chk("idle_busy_done", {busy, done}, 2'b00);
    strobes("idle_strobes", 4'b0000);

    // Straight-line: two ALU ops with RegWrite, then halt; req stays high throughout
    req = 1;
    tick(); RegWrite = 1; #1;
    strobes("s_f0", 4'b1000);
    chk("s_f0_pc", prog_ctr, 0);
    chk("s_f0_busy", busy, 1);
    tick(); #1;
    strobes("s_e0", 4'b0100);
    tick(); #1;
    strobes("s_f1", 4'b1000);
    chk("s_f1_pc", prog_ctr, 1);
    tick(); #1;
    strobes("s_e1", 4'b0100);
    tick(); halt = 1; #1;
    chk("s_f2_pc", prog_ctr, 2);
    tick(); #1;
    strobes("s_e2_halt", 4'b0000);
    chk("s_e2_done", done, 0);
    tick(); clr_dec(); #1;
    chk("s_done", done, 1);
    chk("s_done_busy", busy, 0);
    chk("s_done_ct", cycle_ct, 6);
    chk("s_done_pc", prog_ctr, 2);
    tick(); #1;
    chk("s_done_hold", done, 1);
    req = 0;
    tick(); #1;
    chk("s_idle_done", done, 0);
    chk("s_idle_pc_hold", prog_ctr, 2);
    chk("s_idle_ct_hold", cycle_ct, 6);

    // Store then load (load with MemWrite also set must not store)
    req = 1;
    tick(); req = 0; MemWrite = 1; #1;
    chk("ls_f0_pc", prog_ctr, 0);
    chk("ls_ct_clear", cycle_ct, 0);
    tick(); #1;
    strobes("ls_e0_store", 4'b0010);
    tick(); clr_dec(); MemtoReg = 1; MemWrite = 1; RegWrite = 1; #1;
    strobes("ls_f1", 4'b1000);
    chk("ls_f1_pc", prog_ctr, 1);
    tick(); #1;
    strobes("ls_e1_load", 4'b0001);
    tick(); #1;
    strobes("ls_memwait", 4'b0100);
    chk("ls_memwait_pc", prog_ctr, 1);
    chk("ls_memwait_busy", busy, 1);
    tick(); clr_dec(); Branch = 1; cond = 1; target = 10'h2A; #1;
    chk("ls_pc2", prog_ctr, 2);
    chk("ls_ct5", cycle_ct, 5);

    // Branch taken, not taken, and to its own address
    tick(); #1;
    tick(); cond = 0; #1;
    chk("br_taken", prog_ctr, 10'h2A);
    tick(); #1;
    tick(); cond = 1; target = 10'h2B; #1;
    chk("br_fall", prog_ctr, 10'h2B);
    tick(); #1;
    tick(); clr_dec(); halt = 1; #1;
    chk("br_self", prog_ctr, 10'h2B);
    tick(); #1;
    tick(); clr_dec(); #1;
    chk("br_done", done, 1);
    tick(); #1;
    chk("br_idle", {busy, done}, 2'b00);

    // Reset during MEMWAIT acts asynchronously
    req = 1;
    tick(); req = 0; MemtoReg = 1; #1;
    tick(); #1;
    strobes("rm_exec", 4'b0001);
    tick();
    reset = 0; #1;
    chk("rm_reg_we", reg_we, 0);
    chk("rm_busy_done", {busy, done}, 2'b00);
    chk("rm_pc", prog_ctr, 0);
    tick(); #1;
    strobes("rm_strobes", 4'b0000);

    // Wrap and saturation on the second instance
    clr_dec(); reset = 1; req = 1;
    tick(); req = 0; RegWrite = 1; #1;
    chk("w_start", prog_ctr2, 10'h3FF);
    tick(); #1;
    tick(); #1;
    chk("w_wrap", prog_ctr2, 10'h000);
    repeat (18) tick();
    #1;
    chk("w_fetch", fetch_en2, 1);
    chk("w_ct_full", cycle_ct, 20);
    chk("w_ct_sat", cycle_ct2, 4'hF);
    chk("w_pc_main", prog_ctr, 10);
    halt = 1;
    tick(); #1;
    tick(); #1;
    chk("w_done", {done, done2}, 2'b11);
    chk("w_ct_sat_done", cycle_ct2, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
